// File: rtl/serial_bus_arbiter.sv
// rtl/serial_bus_arbiter.sv - round-robin arbiter sharing one serial byte transmitter between requesters
module serial_bus_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int SERIAL_BITS  = 8,
  parameter int SETUP_CYCLES = 2,
  parameter int GAP_CYCLES   = 4,
  parameter int IDX_BITS     = $clog2(NUM_REQ)
) (
  input  logic                           in_clk,
  input  logic                           in_rst,
  input  logic [NUM_REQ-1:0]             in_req,
  input  logic [NUM_REQ*SERIAL_BITS-1:0] in_data,
  input  logic [NUM_REQ-1:0]             in_dc,
  input  logic [NUM_REQ-1:0]             in_last,
  output logic [NUM_REQ-1:0]             out_grant,
  output logic [NUM_REQ-1:0]             out_next,
  output logic                           out_busy,
  output logic                           out_ser_enable,
  output logic [SERIAL_BITS-1:0]         out_ser_data,
  input  logic                           in_ser_next_word,
  output logic                           out_dc,
  output logic                           out_cs
);

  localparam int MAX_WAIT = (SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES;
  localparam int CNT_BITS = $clog2(MAX_WAIT) + 1;
  localparam logic [CNT_BITS-1:0] SETUP_LAST = CNT_BITS'(SETUP_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] GAP_LAST   = CNT_BITS'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SETUP    = 2'd1,
    S_TRANSFER = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_BITS-1:0]  wait_cnt;
  logic [IDX_BITS-1:0]  rr_ptr;
  logic [IDX_BITS-1:0]  rr_ptr_nxt;
  logic [IDX_BITS-1:0]  gnt_idx;
  logic [IDX_BITS-1:0]  gnt_idx_nxt;
  logic [IDX_BITS-1:0]  cand;
  logic                 last_next_word;
  logic                 byte_done;
  logic [NUM_REQ-1:0]   grant_vec;

  // Only a rising edge of the transmitter's level finishes a byte; a level
  // left high from a previous byte is ignored.
  assign byte_done = in_ser_next_word & ~last_next_word;
  assign grant_vec = NUM_REQ'(1) << gnt_idx;

  // State register with arbitration pointer, latched winner, wait counter and edge history
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      state          <= S_IDLE;
      rr_ptr         <= '0;
      gnt_idx        <= '0;
      wait_cnt       <= '0;
      last_next_word <= 1'b0;
    end else begin
      state          <= state_nxt;
      rr_ptr         <= rr_ptr_nxt;
      gnt_idx        <= gnt_idx_nxt;
      last_next_word <= in_ser_next_word;
      if (state_nxt != state) begin
        wait_cnt <= '0;
      end else if (state == S_SETUP || state == S_RELEASE) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // Next-state logic: round-robin pick in Idle, fixed-length Setup/Release, in_last ends Transfer
  always_comb begin
    state_nxt   = state;
    rr_ptr_nxt  = rr_ptr;
    gnt_idx_nxt = gnt_idx;
    cand        = '0;
    case (state)
      S_IDLE: begin
        // Scan downward so the closest requester at or above rr_ptr wins last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
          cand = IDX_BITS'((int'(rr_ptr) + k) % NUM_REQ);
          if (in_req[cand]) begin
            gnt_idx_nxt = cand;
            state_nxt   = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        if (wait_cnt == SETUP_LAST) begin
          state_nxt = S_TRANSFER;
        end
      end
      S_TRANSFER: begin
        if (byte_done && in_last[gnt_idx]) begin
          state_nxt  = S_RELEASE;
          rr_ptr_nxt = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + IDX_BITS'(1);
        end
      end
      S_RELEASE: begin
        if (wait_cnt == GAP_LAST) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: bus lines follow the state, data/dc muxed from the granted requester
  always_comb begin
    out_grant      = '0;
    out_next       = '0;
    out_busy       = 1'b0;
    out_ser_enable = 1'b0;
    out_ser_data   = '0;
    out_dc         = 1'b0;
    out_cs         = 1'b1;
    case (state)
      S_SETUP: begin
        out_grant = grant_vec;
        out_busy  = 1'b1;
        out_cs    = 1'b0;
      end
      S_TRANSFER: begin
        out_grant      = grant_vec;
        out_busy       = 1'b1;
        out_cs         = 1'b0;
        out_ser_enable = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (gnt_idx == IDX_BITS'(i)) begin
            out_ser_data = in_data[i*SERIAL_BITS +: SERIAL_BITS];
            out_dc       = in_dc[i];
          end
        end
        // A reset in this cycle aborts the transaction, so the byte is not acknowledged.
        if (byte_done && in_rst) begin
          out_next = grant_vec;
        end
      end
      S_RELEASE: begin
        out_busy = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// tb/tb_serial_bus_arbiter.sv - directed and randomized check of serial_bus_arbiter against a timeline model
module tb_serial_bus_arbiter;

  localparam int N            = 2;
  localparam int SB           = 8;
  localparam int SETUP        = 2;
  localparam int GAP          = 4;
  localparam int BYTE_CYC     = 16;
  localparam int NW_HIGH_FROM = 13;

  typedef struct packed {
    logic [SB-1:0] d;
    logic          dc;
    logic          last;
  } byte_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*SB-1:0] data_in;
  logic [N-1:0]    dc_in;
  logic [N-1:0]    last_in;
  logic [N-1:0]    grant;
  logic [N-1:0]    nxt;
  logic            busy;
  logic            ser_en;
  logic [SB-1:0]   ser_data;
  logic            ser_nw;
  logic            dc_out;
  logic            cs;

  always #5 clk = ~clk;

  serial_bus_arbiter #(
    .NUM_REQ(N), .SERIAL_BITS(SB), .SETUP_CYCLES(SETUP), .GAP_CYCLES(GAP)
  ) dut (
    .in_clk(clk), .in_rst(rst_n), .in_req(req), .in_data(data_in), .in_dc(dc_in),
    .in_last(last_in), .out_grant(grant), .out_next(nxt), .out_busy(busy),
    .out_ser_enable(ser_en), .out_ser_data(ser_data), .in_ser_next_word(ser_nw),
    .out_dc(dc_out), .out_cs(cs)
  );

  // Requester byte queues and environment drive values
  byte_t        q [N][$];
  logic [N-1:0] req_mask;
  logic         rst_drv;
  int           tx_cnt;
  logic         tx_nw;

  // Timeline model: who owns the bus, when it was granted, when it was released
  int   cyc;
  int   owner;
  int   t_grant;
  int   t_rel;
  int   ptr;
  logic prev_nw;
  int   next_cnt [N];
  int   t_last_done [N];
  int   grant_log [$];
  int   grant_t_log [$];

  int checks;
  int errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic int rr_winner(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (((r >> ((p + k) % N)) & 1) != 0) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic int log_at(input int k);
    return (grant_log.size() > k) ? grant_log[k] : -1;
  endfunction

  task automatic push_byte(input int i, input logic [SB-1:0] d, input logic dc, input logic last);
    byte_t b;
    b.d = d;
    b.dc = dc;
    b.last = last;
    q[i].push_back(b);
  endtask

  task automatic push_txn(input int i, input int len);
    for (int b = 0; b < len; b++) push_byte(i, 8'($urandom), 1'($urandom), b == len - 1);
  endtask

  task automatic drive();
    rst_n  = rst_drv;
    ser_nw = tx_nw;
    for (int i = 0; i < N; i++) begin
      req[i] = req_mask[i] && (q[i].size() > 0);
      if (q[i].size() > 0) begin
        data_in[i*SB +: SB] = q[i][0].d;
        dc_in[i]            = q[i][0].dc;
        last_in[i]          = q[i][0].last;
      end else begin
        data_in[i*SB +: SB] = '0;
        dc_in[i]            = 1'b0;
        last_in[i]          = 1'b0;
      end
    end
  endtask

  task automatic sample();
    logic         rst_act;
    logic         xfer;
    logic         bd;
    logic [N-1:0] e_grant;
    logic [N-1:0] e_next;
    byte_t        head;
    rst_act = !rst_n;
    xfer    = (owner >= 0) && (cyc - t_grant >= SETUP);
    bd      = ser_nw && !prev_nw;
    e_grant = (owner >= 0) ? (N'(1) << owner) : '0;
    head    = '0;
    if (owner >= 0 && q[owner].size() > 0) head = q[owner][0];
    e_next  = (!rst_act && xfer && bd) ? e_grant : '0;

    chk("grant", grant, e_grant);
    chk("cs", cs, owner < 0);
    chk("busy", busy, (owner >= 0) || (cyc < t_rel + GAP));
    chk("ser_enable", ser_en, xfer);
    chk("ser_data", ser_data, xfer ? head.d : '0);
    chk("dc", dc_out, xfer ? head.dc : 1'b0);
    chk("next", nxt, e_next);

    // Transmitter: idle level high, then 16 cycles per byte with the level rising at count 13
    tx_cnt = ser_en ? (tx_cnt + 1) % BYTE_CYC : 0;
    tx_nw  = ser_en ? (tx_cnt >= NW_HIGH_FROM) : 1'b1;

    prev_nw = rst_act ? 1'b0 : ser_nw;
    if (rst_act) begin
      owner = -1;
      t_rel = cyc + 1 - GAP;
      ptr   = 0;
    end else if (e_next != '0) begin
      next_cnt[owner]++;
      if (head.last) begin
        t_last_done[owner] = cyc;
        ptr   = (owner + 1) % N;
        owner = -1;
        t_rel = cyc + 1;
      end
    end else if (owner < 0 && cyc >= t_rel + GAP && req != '0) begin
      owner   = rr_winner(req, ptr);
      t_grant = cyc + 1;
      grant_log.push_back(owner);
      grant_t_log.push_back(t_grant);
    end

    for (int i = 0; i < N; i++) begin
      if (nxt[i] && q[i].size() > 0) void'(q[i].pop_front());
    end
    cyc++;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1 drive();
    #1 sample();
  endtask

  task automatic drain(input int max_cyc);
    int n;
    int pending;
    n = 0;
    pending = 1;
    while (pending != 0 && n < max_cyc) begin
      cycle();
      n++;
      pending = (owner >= 0 || cyc < t_rel + GAP) ? 1 : 0;
      for (int i = 0; i < N; i++) if (q[i].size() > 0) pending = 1;
    end
    chk("drain_in_budget", n < max_cyc, 1'b1);
  endtask

  task automatic wait_next(input int i, input int max_cyc);
    int n;
    int c0;
    n = 0;
    c0 = next_cnt[i];
    while (next_cnt[i] == c0 && n < max_cyc) begin
      cycle();
      n++;
    end
    chk("next_in_budget", n < max_cyc, 1'b1);
  endtask

  int base;
  int t_req;
  int r;
  int rr_exp [4] = '{0, 1, 0, 1};

  initial begin
    checks = 0; errors = 0; cyc = 0; owner = -1; t_grant = 0; t_rel = -GAP; ptr = 0;
    prev_nw = 1'b0; tx_cnt = 0; tx_nw = 1'b1; req_mask = '0; rst_drv = 1'b0;
    for (int i = 0; i < N; i++) begin
      next_cnt[i] = 0;
      t_last_done[i] = 0;
    end
    rst_n = 1'b0; req = '0; data_in = '0; dc_in = '0; last_in = '0; ser_nw = 1'b1;

    // Reset held 3 cycles with both requesting: bus stays idle
    push_txn(0, 1); push_txn(0, 1); push_txn(1, 1); push_txn(1, 1);
    req_mask = 2'b11;
    repeat (3) cycle();
    chk("reset_no_grant", grant_log.size(), 0);

    // Round-robin from reset with requester 0 re-requesting at once
    rst_drv = 1'b1;
    drain(400);
    chk("rr_count", grant_log.size(), 4);
    for (int k = 0; k < 4; k++) chk("rr_order", log_at(k), rr_exp[k]);

    // Single two-byte transaction from requester 0
    grant_log.delete(); grant_t_log.delete();
    push_byte(0, 8'h36, 1'b0, 1'b0);
    push_byte(0, 8'h48, 1'b1, 1'b1);
    req_mask = 2'b01;
    base = next_cnt[0];
    t_req = cyc;
    drain(200);
    chk("single_next_count", next_cnt[0] - base, 2);
    chk("single_grant_latency", grant_t_log.size() > 0 ? grant_t_log[0] - t_req : -1, 1);

    // Requester 1 arrives mid-transaction and must wait for the release gap
    grant_log.delete(); grant_t_log.delete();
    push_txn(0, 3);
    push_txn(1, 1);
    req_mask = 2'b01;
    wait_next(0, 100);
    req_mask = 2'b11;
    drain(500);
    chk("nonpreempt_first", log_at(0), 0);
    chk("nonpreempt_second", log_at(1), 1);
    chk("nonpreempt_gap", grant_t_log.size() > 1 && grant_t_log[1] - t_last_done[0] >= 5, 1'b1);

    // Dropping the request after the first byte does not end the transaction
    base = next_cnt[0];
    push_txn(0, 3);
    req_mask = 2'b01;
    wait_next(0, 100);
    req_mask = 2'b00;
    drain(500);
    chk("reqdrop_next_count", next_cnt[0] - base, 3);

    // Reset lands on the cycle the second byte finishes; requester 1 then wins from ptr 0
    push_txn(0, 2);
    req_mask = 2'b01;
    wait_next(0, 100);
    repeat (BYTE_CYC - 1) cycle();
    base = next_cnt[0];
    rst_drv = 1'b0;
    cycle();
    rst_drv = 1'b1;
    chk("reset_mid_no_next", next_cnt[0] - base, 0);
    q[0].delete();
    grant_log.delete(); grant_t_log.delete();
    push_txn(1, 1);
    req_mask = 2'b10;
    drain(200);
    chk("post_reset_count", grant_log.size(), 1);
    chk("post_reset_winner", log_at(0), 1);

    // Randomized traffic with request masks toggling underneath
    req_mask = 2'b11;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(11) == 0) begin
        r = $urandom_range(N - 1);
        if (q[r].size() < 6) push_txn(r, $urandom_range(3, 1));
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) req_mask[i] = ~req_mask[i];
      end
      cycle();
    end
    req_mask = 2'b11;
    drain(4000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_bus_arbiter.md
Name: serial_bus_arbiter

Overview:
- Shares one serial byte transmitter (SPI-style display link) between NUM_REQ requesters, e.g. an init-sequence engine and a pixel streamer.
- Grants the transmitter round-robin, one whole transaction at a time.
- Drives the transmitter's enable/data lines, a per-byte data/command flag and the display chip select.
- Edge-detects the transmitter's byte-finished level to pace each requester byte by byte.

Parameters:
- NUM_REQ, 2, number of requesters (≥2)
- SERIAL_BITS, 8, bits per serial word
- SETUP_CYCLES, 2, cycles between chip-select assertion and transmitter enable (≥1)
- GAP_CYCLES, 4, cycles chip select stays deasserted between transactions (≥1)
- IDX_BITS, $clog2(NUM_REQ), requester index width

Ports:
- in_clk, in, 1, system clock
- in_rst, in, 1, reset; synchronous, active-low
- in_req, in, NUM_REQ, per-requester bus request (level)
- in_data, in, NUM_REQ*SERIAL_BITS, flattened byte per requester; requester i occupies bits [i*SERIAL_BITS +: SERIAL_BITS]
- in_dc, in, NUM_REQ, data(1)/command(0) flag accompanying each requester's current byte
- in_last, in, NUM_REQ, marks requester's current byte as final byte of its transaction
- out_grant, out, NUM_REQ, one-hot grant
- out_next, out, NUM_REQ, one-cycle pulse to granted requester: current byte accepted, present next
- out_busy, out, 1, high in any state except Idle
- out_ser_enable, out, 1, transmitter enable
- out_ser_data, out, SERIAL_BITS, transmitter parallel word
- in_ser_next_word, in, 1, transmitter byte-finished level
- out_dc, out, 1, data/command line to display
- out_cs, out, 1, chip select, active-low

Behaviour:
- Reset (in_rst=0 at a rising in_clk edge):
  - State → Idle; rr pointer → 0; wait counter → 0; registered last_next_word → 0.
  - Outputs: out_grant=0, out_next=0, out_busy=0, out_ser_enable=0, out_ser_data=0, out_dc=0, out_cs=1.
  - Applies mid-transaction too: the transmitter is disabled immediately and no out_next pulse occurs.
- byte_done = in_ser_next_word & ~last_next_word (combinational); last_next_word is registered every cycle.
- States: Idle, Setup, Transfer, Release.
- Idle:
  - All outputs at their reset values.
  - If any in_req is high, choose the winner g: first requester with in_req high, searching from index ptr upward with wrap-around mod NUM_REQ.
  - Latch g; next state Setup; wait counter cleared.
- Setup:
  - out_grant[g]=1, out_cs=0, out_ser_enable=0.
  - Lasts exactly SETUP_CYCLES cycles, then Transfer.
- Transfer:
  - out_grant[g]=1, out_cs=0, out_ser_enable=1.
  - out_ser_data=in_data[g], out_dc=in_dc[g], both combinational mux of the granted slice.
  - On byte_done: out_next[g]=1 for that same cycle.
    - If in_last[g]=1 in that cycle: next state Release, ptr ← (g+1) mod NUM_REQ.
    - Otherwise: stay in Transfer.
  - in_req[g] is ignored once granted; only in_last ends a transaction.
  - Requests from other requesters never preempt the granted one.
- Release:
  - out_grant=0, out_cs=1, out_ser_enable=0, out_ser_data=0, out_dc=0.
  - Lasts exactly GAP_CYCLES cycles, then Idle.
  - Requests are not sampled during Release.
- Latency:
  - in_req rising in Idle → out_grant and out_cs low on the next cycle.
  - out_ser_enable asserts SETUP_CYCLES cycles after out_cs falls.
  - Last byte_done → out_cs high on the next cycle.
  - Minimum request-to-request turnaround: GAP_CYCLES+1 cycles of deasserted grant.
- Simultaneous requests: resolved purely by round-robin order. A requester that just finished has lowest priority in the next arbitration.
- Only one out_grant bit is ever high; out_next is only ever asserted on the granted index.
- Wait counter width is $clog2(max(SETUP_CYCLES,GAP_CYCLES))+1 and it is reset on every state entry.
- in_ser_next_word high at entry to Transfer (left over from an earlier byte) does not cause byte_done; only a rising edge counts.

Test Plan:
- Reset: hold in_rst=0 for 3 cycles with in_req=2'b11 → out_cs=1, out_grant=0, out_ser_enable=0, out_busy=0 throughout.
- Single transaction: requester 0 sends 8'h36 (dc=0), then 8'h48 (dc=1, last=1); transmitter model takes 16 cycles per byte → out_cs low 1 cycle after req, enable 2 cycles later, serial shows 36h then 48h with dc 0/1, exactly two out_next[0] pulses, cs high 1 cycle after the second pulse and held 4 cycles.
- Round-robin: in_req=2'b11 from reset, each transaction one byte → grant order 0,1,0,1; with requester 0 re-requesting immediately, requester 1 is never skipped.
- Non-preemption: requester 1 asserts req during requester 0's 3-byte transaction → requester 1 granted only after Release completes (≥5 cycles after requester 0's last out_next).
- Req drop ignored: requester 0 deasserts in_req after its first byte without last → transfer continues until a byte with in_last=1 completes.
- Reset mid-Transfer: in_rst=0 during the second byte → next cycle out_ser_enable=0, out_cs=1, no out_next; after release, in_req=2'b10 → requester 1 granted (ptr=0, searching upward finds 1).
